result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 109 ++++++++++
 1 files changed

// File: rtl/result_display.sv
// result_display: signed 20-bit result to BCD via double-dabble, plus multiplexed 7-segment scan
// Ports: clk, rst (async high); res_in/res_valid/res_ready accept a result;
// bcd/neg/done report the converted magnitude and sign; an/seg drive the display (active-low).
module result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] res_in,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [23:0] bcd,
  output logic        neg,
  output logic        done,
  output logic [6:0]  an,
  output logic [6:0]  seg
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [19:0] SCAN_MAX = 20'(SCAN_DIV - 1);
  state_t      r_state, w_next;
  logic [43:0] r_sh, w_adj;
  logic [4:0]  r_cnt;
  logic        r_neg_pend, r_neg, r_done;
  logic [23:0] r_bcd;
  logic [19:0] r_scan, w_mag;
  logic [2:0]  r_idx, w_m;
  logic [27:0] w_ext;
  logic [3:0]  w_dig;
  logic [6:0]  w_dseg;
  // 0x80000 negates to itself, which read unsigned is exactly 524288
  assign w_mag = res_in[19] ? ~res_in + 20'd1 : res_in;
  always_comb begin
    w_adj = r_sh;
    for (int k = 0; k < 6; k++)
      if (r_sh[20+4*k +: 4] >= 4'd5) w_adj[20+4*k +: 4] = r_sh[20+4*k +: 4] + 4'd3;
  end
  always_comb begin
    w_next = r_state == IDLE ? (res_valid ? CONV : IDLE) :
             r_state == CONV ? (r_cnt == 5'd19 ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_neg_pend <= 1'b0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == IDLE && res_valid) begin
        r_sh       <= {24'd0, w_mag};
        r_neg_pend <= res_in[19];
        r_cnt      <= '0;
      end
      if (r_state == CONV) begin
        r_sh  <= {w_adj[42:0], 1'b0};
        r_cnt <= r_cnt + 5'd1;
      end
      if (r_state == DONE) begin
        r_bcd  <= r_sh[43:20];
        r_neg  <= r_neg_pend;
        r_done <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      r_scan <= r_scan == SCAN_MAX ? 20'd0 : r_scan + 20'd1;
      if (r_scan == SCAN_MAX) r_idx <= r_idx == 3'd6 ? 3'd0 : r_idx + 3'd1;
    end
  end
  // m: index of the most significant nonzero digit, 0 for a zero magnitude
  always_comb begin
    w_m = 3'd0;
    for (int k = 1; k < 6; k++)
      if (r_bcd[4*k +: 4] != 4'd0) w_m = 3'(k);
  end
  assign w_ext = {4'd0, r_bcd};
  assign w_dig = w_ext[{r_idx, 2'b00} +: 4];
  always_comb begin
    w_dseg = 7'h7F;
    case (w_dig)
      4'd0: w_dseg = 7'h40;
      4'd1: w_dseg = 7'h79;
      4'd2: w_dseg = 7'h24;
      4'd3: w_dseg = 7'h30;
      4'd4: w_dseg = 7'h19;
      4'd5: w_dseg = 7'h12;
      4'd6: w_dseg = 7'h02;
      4'd7: w_dseg = 7'h78;
      4'd8: w_dseg = 7'h00;
      4'd9: w_dseg = 7'h10;
      default: w_dseg = 7'h7F;
    endcase
  end
  assign seg = r_idx <= w_m ? w_dseg :
               r_idx == w_m + 3'd1 ? (r_neg ? 7'h3F : 7'h7F) : 7'h7F;
  assign an        = ~(7'b1 << r_idx);
  assign res_ready = r_state == IDLE;
  assign bcd       = r_bcd;
  assign neg       = r_neg;
  assign done      = r_done;
endmodule
